// File: rtl/light_sequencer.sv
// Five-lamp pattern sequencer stepped by VGA frame ticks (FILL/CHASE/BLINK/BOUNCE).
// Configuration is latched at start; all outputs are registered.
module light_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        start,
   input  logic        stop,
   input  logic [1:0]  mode,
   input  logic [5:0]  period,
   input  logic [11:0] color,
   input  logic [7:0]  max_passes,
   output logic [4:0]  light_en,
   output logic [11:0] light_rgb,
   output logic        busy,
   output logic        pass_done,
   output logic [7:0]  pass_count
);
   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic [1:0]  mode;
      logic [5:0]  period;
      logic [11:0] color;
      logic [7:0]  max_passes;
   } cfg_t;

   localparam logic [1:0] M_FILL  = 2'd0;
   localparam logic [1:0] M_CHASE = 2'd1;
   localparam logic [1:0] M_BLINK = 2'd2;

   state_t     state_q, state_d;
   cfg_t       cfg_q;
   logic       origin, origin_q, tick;
   logic [5:0] frame_cnt;
   logic [2:0] step, step_nxt, last_step;
   logic       step_adv, pass_end, auto_stop, go;
   logic [7:0] pc_inc;

   function automatic logic [4:0] pattern(input logic [1:0] m, input logic [2:0] s);
      logic [5:0] fill;
      logic [4:0] p;
      fill = (6'd2 << s) - 6'd1;
      p    = '0;
      case (m)
         M_FILL:  p = fill[4:0];
         M_CHASE: p = 5'd1 << s;
         M_BLINK: p = (s == 3'd0) ? 5'h1F : 5'h00;
         // BOUNCE: steps 5..7 walk back as lamps 3,2,1 (8-s wraps to 0-s in 3 bits)
         default: p = (s <= 3'd4) ? (5'd1 << s) : (5'd1 << (3'd0 - s));
      endcase
      return p;
   endfunction

   assign origin    = (pix_x == 10'd0) && (pix_y == 10'd0);
   assign tick      = origin && !origin_q;
   assign go        = start && !stop;
   assign last_step = (cfg_q.mode == M_BLINK) ? 3'd1 :
                      (cfg_q.mode == M_FILL || cfg_q.mode == M_CHASE) ? 3'd4 : 3'd7;
   assign step_adv  = tick && (({1'b0, frame_cnt} + 7'd1) == {1'b0, cfg_q.period});
   assign pass_end  = step_adv && (step == last_step);
   assign step_nxt  = pass_end ? 3'd0 : step + 3'd1;
   assign pc_inc    = (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;
   assign auto_stop = pass_end && (cfg_q.max_passes != 8'd0) && (pc_inc == cfg_q.max_passes);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = RUN;
         RUN:     if (stop || auto_stop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_q      <= '0;
         origin_q   <= 1'b0;
         frame_cnt  <= '0;
         step       <= '0;
         light_en   <= '0;
         light_rgb  <= '0;
         busy       <= 1'b0;
         pass_done  <= 1'b0;
         pass_count <= '0;
      end else begin
         origin_q  <= origin;
         pass_done <= 1'b0;
         if (state_q == IDLE) begin
            if (go) begin
               cfg_q.mode       <= mode;
               cfg_q.period     <= (period == 6'd0) ? 6'd1 : period;
               cfg_q.color      <= color;
               cfg_q.max_passes <= max_passes;
               frame_cnt        <= '0;
               step             <= '0;
               pass_count       <= '0;
               light_en         <= pattern(mode, 3'd0);
               light_rgb        <= color;
               busy             <= 1'b1;
            end
         end else if (stop) begin
            light_en  <= '0;
            light_rgb <= '0;
            busy      <= 1'b0;
         end else if (tick) begin
            if (step_adv) begin
               frame_cnt <= '0;
               step      <= step_nxt;
               light_en  <= pattern(cfg_q.mode, step_nxt);
               if (pass_end) begin
                  pass_done  <= 1'b1;
                  pass_count <= pc_inc;
               end
               if (auto_stop) begin
                  light_en  <= '0;
                  light_rgb <= '0;
                  busy      <= 1'b0;
               end
            end else begin
               frame_cnt <= frame_cnt + 6'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: directed scenarios plus random traffic against a
// tick-count reference model (step = ticks/period mod L, passes = ticks/(period*L)).
module tb_light_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  pix_x = 10'd5, pix_y = 10'd5;
   logic        start = 1'b0, stop = 1'b0;
   logic [1:0]  mode = '0;
   logic [5:0]  period = '0;
   logic [11:0] color = '0;
   logic [7:0]  max_passes = '0;
   logic [4:0]  light_en;
   logic [11:0] light_rgb;
   logic        busy, pass_done;
   logic [7:0]  pass_count;

   int n_vec = 0, n_bad = 0;
   bit chk_en = 1'b0;

   light_sequencer dut (
      .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
      .start(start), .stop(stop), .mode(mode), .period(period),
      .color(color), .max_passes(max_passes), .light_en(light_en),
      .light_rgb(light_rgb), .busy(busy), .pass_done(pass_done),
      .pass_count(pass_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: counts frame ticks since start, derives everything else.
   bit          m_run, m_pd, m_org;
   int          m_ticks, m_pc, m_per, m_len, m_max, m_mode;
   logic [11:0] m_col;

   function automatic logic [4:0] pat(input int m, input int s);
      int v;
      case (m)
         0:       v = (1 << (s + 1)) - 1;
         1:       v = 1 << s;
         2:       v = (s == 0) ? 31 : 0;
         default: v = 1 << ((s < 5) ? s : 8 - s);
      endcase
      return 5'(v);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_run <= 1'b0; m_pd <= 1'b0; m_org <= 1'b0; m_ticks <= 0; m_pc <= 0;
      end else begin
         automatic bit org = (pix_x == 0) && (pix_y == 0);
         automatic bit tk  = org && !m_org;
         automatic int t   = m_ticks + 1;
         automatic int pc  = (m_pc == 255) ? 255 : m_pc + 1;
         m_org <= org;
         m_pd  <= 1'b0;
         if (!m_run) begin
            if (start && !stop) begin
               m_run   <= 1'b1;
               m_mode  <= int'(mode);
               m_per   <= (period == 0) ? 1 : int'(period);
               m_len   <= (mode == 3) ? 8 : (mode == 2) ? 2 : 5;
               m_col   <= color;
               m_max   <= int'(max_passes);
               m_ticks <= 0;
               m_pc    <= 0;
            end
         end else if (stop) begin
            m_run <= 1'b0;
         end else if (tk) begin
            m_ticks <= t;
            if (t % (m_per * m_len) == 0) begin
               m_pd <= 1'b1;
               m_pc <= pc;
               if (m_max != 0 && pc == m_max) m_run <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("light_en",   light_en,
             m_run ? pat(m_mode, (m_ticks / m_per) % m_len) : 5'd0);
         chk("light_rgb",  light_rgb, m_run ? m_col : 12'h000);
         chk("busy",       busy, m_run);
         chk("pass_done",  pass_done, m_pd);
         chk("pass_count", pass_count, m_pc[7:0]);
      end
   end

   task automatic cyc(input bit org);
      @(negedge clk);
      pix_x = org ? 10'd0 : 10'($urandom_range(1, 799));
      pix_y = org ? 10'd0 : 10'($urandom_range(0, 524));
   endtask

   task automatic frames(input int n, input int hold, input int gap);
      repeat (n) begin
         repeat (hold) cyc(1'b1);
         repeat (gap) cyc(1'b0);
      end
   endtask

   task automatic do_start(input logic [1:0] m, input logic [5:0] p,
                           input logic [11:0] c, input logic [7:0] mx);
      mode = m; period = p; color = c; max_passes = mx;
      start = 1'b1; cyc(1'b0); start = 1'b0;
   endtask

   initial begin
      int hold;
      // reset state
      repeat (3) cyc(1'b0);
      chk("rst_en", light_en, 5'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pc", pass_count, 8'd0);
      reset = 1'b1;
      chk_en = 1'b1;
      cyc(1'b0);

      // start+stop together in IDLE: stop wins
      start = 1'b1; stop = 1'b1; cyc(1'b0); start = 1'b0; stop = 1'b0;
      cyc(1'b0);
      chk("startstop_busy", busy, 1'b0);

      // FILL, period 2, origin held 4 clocks per frame
      do_start(2'd0, 6'd2, 12'hF00, 8'd0);
      chk("fill_step0", light_en, 5'b00001);
      frames(10, 4, 3);
      chk("fill_pc1", pass_count, 8'd1);
      chk("fill_rgb", light_rgb, 12'hF00);
      frames(3, 4, 3);
      stop = 1'b1; cyc(1'b0); stop = 1'b0;

      // CHASE, period 0 -> 1, auto-stop after 2 passes
      do_start(2'd1, 6'd0, 12'h0F0, 8'd2);
      frames(12, 1, 2);
      chk("chase_pc2", pass_count, 8'd2);
      chk("chase_busy", busy, 1'b0);
      chk("chase_en", light_en, 5'd0);

      // BOUNCE, period 1
      do_start(2'd3, 6'd1, 12'h00F, 8'd0);
      frames(17, 2, 2);
      stop = 1'b1; cyc(1'b0); stop = 1'b0;

      // BLINK ignores mode change in RUN; restart picks up FILL
      do_start(2'd2, 6'd1, 12'hABC, 8'd0);
      frames(1, 1, 2);
      mode = 2'd0;
      frames(2, 1, 2);
      stop = 1'b1; cyc(1'b0); stop = 1'b0;
      do_start(2'd0, 6'd1, 12'h123, 8'd0);
      chk("restart_fill", light_en, 5'b00001);
      stop = 1'b1; cyc(1'b0); stop = 1'b0;

      // asynchronous reset during BLINK step 0 with pass_count > 0
      do_start(2'd2, 6'd1, 12'h5A5, 8'd0);
      frames(4, 1, 2);
      chk("blink_pc_pre", pass_count, 8'd2);
      #3 reset = 1'b0;
      #1;
      chk("async_en", light_en, 5'd0);
      chk("async_pc", pass_count, 8'd0);
      chk("async_busy", busy, 1'b0);
      chk("async_pd", pass_done, 1'b0);
      cyc(1'b0);
      reset = 1'b1;
      frames(3, 1, 2);

      // random traffic
      hold = 0;
      repeat (15000) begin
         start = ($urandom % 10) == 0;
         stop  = ($urandom % 250) == 0;
         if (($urandom % 16) == 0) begin
            mode       = 2'($urandom);
            period     = 6'($urandom_range(0, 3));
            color      = 12'($urandom);
            max_passes = 8'($urandom_range(0, 3));
         end
         if (hold > 0) begin
            cyc(1'b1);
            hold--;
         end else begin
            cyc(1'b0);
            if (($urandom % 5) == 0) hold = $urandom_range(1, 4);
         end
      end
      start = 1'b0; stop = 1'b0;
      cyc(1'b0);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 Parameters: none; lamp count fixed at 5; all widths fixed as listed.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-004 pix_x  in  10  current VGA pixel column from sync generator.
REQ-005 pix_y  in  10  current VGA pixel row from sync generator.
REQ-006 start  in  1  level-sampled request to begin a sequence.
REQ-007 stop  in  1  level-sampled request to abort the sequence.
REQ-008 mode  in  2  pattern: 0 FILL, 1 CHASE, 2 BLINK, 3 BOUNCE.
REQ-009 period  in  6  frames per step; 0 treated as 1.
REQ-010 color  in  12  RGB444 colour for lit lamps.
REQ-011 max_passes  in  8  passes before auto-stop; 0 = run until stop.
REQ-012 light_en  out  5  per-lamp enable; bit0 = leftmost box.
REQ-013 light_rgb  out  12  latched colour while RUN, else 12'h000.
REQ-014 busy  out  1  high while in RUN.
REQ-015 pass_done  out  1  one-cycle pulse at each completed pattern pass.
REQ-016 pass_count  out  8  completed passes since last start; saturates at 255.

Function
REQ-017 Frame tick SHALL assert for exactly one clk when (pix_x==0 && pix_y==0) and this condition was false on the previous clk; a frame origin held for several clocks yields one tick.
REQ-018 FSM SHALL have two states, IDLE and RUN; reset state IDLE.
REQ-019 IDLE->RUN on start=1 and stop=0; same edge latches mode, period (0->1), color, max_passes; clears frame counter, step index, pass_count.
REQ-020 RUN->IDLE on stop=1; stop=1 with start=1 in IDLE leaves the FSM in IDLE (stop wins).
REQ-021 start while in RUN SHALL be ignored; input changes to mode/period/color/max_passes in RUN SHALL have no effect until the next start.
REQ-022 In RUN, the 6-bit frame counter increments on each tick; on the tick when counter+1 == latched period, counter clears and step index advances.
REQ-023 Patterns (step index s, L = pattern length): FILL L=5, light_en = (2^(s+1))-1; CHASE L=5, one-hot 1<<s; BLINK L=2, 5'b11111 at s=0, 5'b00000 at s=1; BOUNCE L=8, lamp sequence 0,1,2,3,4,3,2,1 one-hot.
REQ-024 On entering RUN, light_en SHALL show step 0 on the clk following the start edge.
REQ-025 light_en SHALL update on the clk after the tick that advances the step (1-cycle latency, registered).
REQ-026 Step advance from s=L-1 SHALL wrap s to 0, pulse pass_done for one clk, and increment pass_count (saturating at 255).
REQ-027 If latched max_passes != 0 and the incremented pass_count equals it, the FSM SHALL go to IDLE on that same edge; pass_done still pulses.
REQ-028 In IDLE: light_en=0, light_rgb=0, busy=0; pass_count holds its last value until the next start.
REQ-029 stop or auto-stop SHALL clear light_en and light_rgb on the transition edge; no pass_done for an aborted partial pass.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, light_en=0, light_rgb=0, busy=0, pass_done=0, pass_count=0, counters and step index 0, tick-edge register 0.
REQ-032 Reset asserted mid-RUN SHALL abort without pass_done; after release, the block stays IDLE until a new start.

Verification
REQ-033 FILL, period=2, color=12'hF00, max_passes=0: light_en 00001,00011,00111,01111,11111, changing every 2 frames; then 00001 again with pass_done pulse and pass_count=1; light_rgb=12'hF00 throughout.
REQ-034 CHASE, period=0, max_passes=2: one step per frame; after 10 frames, pass_count=2, FSM returns to IDLE, light_en=0, busy=0.
REQ-035 BOUNCE, period=1: one-hot lamp sequence 0,1,2,3,4,3,2,1,0; pass_done pulses once per 8 frames.
REQ-036 Frame origin held for 4 clocks: frame counter advances by exactly 1; start and stop asserted together in IDLE: busy stays 0.
REQ-037 Mode changed 2->0 mid-RUN: pattern remains BLINK; stop, then start: FILL begins at 00001.
REQ-038 reset pulled low during BLINK step 0: light_en=0 and pass_count=0 immediately with no clock edge required; no pass_done.
